// File: rtl/muldiv_controller_if.sv
// Pipeline <-> muldiv_controller <-> shared mult/div unit signal bundle.
// div_zero exists only when MULDIV_DIV0_TRAP_EN is defined.
interface muldiv_controller_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic [2:0]       req_op;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             req_ready;
    logic [WIDTH-1:0] rd_data;
    logic             busy;
    logic [WIDTH-1:0] md_mult_a;
    logic [WIDTH-1:0] md_mult_b;
    logic             md_enable_mult;
    logic             md_signed_mult;
    logic [WIDTH-1:0] md_div_a;
    logic [WIDTH-1:0] md_div_b;
    logic             md_enable_div;
    logic             md_signed_div;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
`ifdef MULDIV_DIV0_TRAP_EN
    logic             div_zero;
`endif

    modport master (
`ifdef MULDIV_DIV0_TRAP_EN
        input  div_zero,
`endif
        output req_valid, req_op, req_a, req_b, md_hi, md_lo,
        input  req_ready, rd_data, busy,
        input  md_mult_a, md_mult_b, md_enable_mult, md_signed_mult,
        input  md_div_a, md_div_b, md_enable_div, md_signed_div
    );

    modport slave (
`ifdef MULDIV_DIV0_TRAP_EN
        output div_zero,
`endif
        input  req_valid, req_op, req_a, req_b, md_hi, md_lo,
        output req_ready, rd_data, busy,
        output md_mult_a, md_mult_b, md_enable_mult, md_signed_mult,
        output md_div_a, md_div_b, md_enable_div, md_signed_div
    );
endinterface

// File: rtl/muldiv_controller.sv
// HI/LO op sequencer for the shared mult/div unit; issue and reads are same-cycle, divides hold
// req_ready low for DIV_LATENCY cycles. Optional divide-by-zero trap under MULDIV_DIV0_TRAP_EN.
module muldiv_controller #(
    parameter int DIV_LATENCY = 11,
    parameter int WIDTH       = 32
) (
    input  logic               clk,
    input  logic               rst,
    muldiv_controller_if.slave bus
);
    localparam int            CW   = $clog2(DIV_LATENCY + 1);
    localparam logic [CW-1:0] LOAD = CW'(DIV_LATENCY);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_MFHI  = 3'd4;
    localparam logic [2:0] OP_MFLO  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic {
        ST_IDLE,
        ST_DIV_BUSY
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_hi_ovr;
    logic [WIDTH-1:0] r_lo_ovr;
    logic             r_hi_ovr_v;
    logic             r_lo_ovr_v;

    logic w_busy;
    logic w_accept;
    logic w_is_mult;
    logic w_is_div;
    logic w_div0;
    logic w_div_issue;

    assign w_busy = (r_cnt != '0);

    // Nothing is accepted while reset is asserted, so every issue output reads 0 in reset.
    always_comb begin
        w_accept    = bus.req_valid && !w_busy && !rst;
        w_is_mult   = w_accept && (bus.req_op[2:1] == 2'b00);
        w_is_div    = w_accept && (bus.req_op[2:1] == 2'b01);
`ifdef MULDIV_DIV0_TRAP_EN
        w_div0      = w_is_div && (bus.req_b == '0);
`else
        w_div0      = 1'b0;
`endif
        w_div_issue = w_is_div && !w_div0;
    end

    assign bus.req_ready      = !w_busy && !rst;
    assign bus.busy           = w_busy;
    assign bus.md_mult_a      = bus.req_a;
    assign bus.md_mult_b      = bus.req_b;
    assign bus.md_div_a       = bus.req_a;
    assign bus.md_div_b       = bus.req_b;
    assign bus.md_enable_mult = w_is_mult;
    assign bus.md_signed_mult = w_is_mult && (bus.req_op == OP_MULT);
    assign bus.md_enable_div  = w_div_issue;
    assign bus.md_signed_div  = w_div_issue && (bus.req_op == OP_DIV);
`ifdef MULDIV_DIV0_TRAP_EN
    assign bus.div_zero       = w_div0;
`endif

    // The unit has no write port: MTHI/MTLO values shadow md_hi/md_lo until the next mult/div.
    always_comb begin
        bus.rd_data = '0;
        if (w_accept && bus.req_op == OP_MFHI) begin
            bus.rd_data = r_hi_ovr_v ? r_hi_ovr : bus.md_hi;
        end else if (w_accept && bus.req_op == OP_MFLO) begin
            bus.rd_data = r_lo_ovr_v ? r_lo_ovr : bus.md_lo;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_div_issue) begin
                        r_state <= ST_DIV_BUSY;
                        r_cnt   <= LOAD;
                    end
                end
                ST_DIV_BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hi_ovr   <= '0;
            r_lo_ovr   <= '0;
            r_hi_ovr_v <= 1'b0;
            r_lo_ovr_v <= 1'b0;
        end else begin
            if (w_is_mult || w_div_issue) begin
                r_hi_ovr_v <= 1'b0;
                r_lo_ovr_v <= 1'b0;
            end
            if (w_accept && bus.req_op == OP_MTHI) begin
                r_hi_ovr   <= bus.req_a;
                r_hi_ovr_v <= 1'b1;
            end
            if (w_accept && bus.req_op == OP_MTLO) begin
                r_lo_ovr   <= bus.req_a;
                r_lo_ovr_v <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_muldiv_controller.sv
// Bench for muldiv_controller: behavioural mult/div unit, architectural HI/LO scoreboard.
module tb_muldiv_controller;
    localparam int DIV_LAT = 11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_controller_if #(.WIDTH(32)) bus ();

    muldiv_controller #(.DIV_LATENCY(DIV_LAT), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] arch_hi = '0;
    logic [31:0] arch_lo = '0;
    int mult_pulses = 0;

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b, input bit s);
        longint sa;
        longint sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        return 64'(sa * sb);
    endfunction

    // returns {remainder, quotient}
    function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b, input bit s);
        int sa;
        int sb;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa % sb), 32'(sa / sb)};
        end
        return {a % b, a / b};
    endfunction

    // Behavioural shared unit: product next cycle, quotient/remainder after DIV_LAT cycles.
    logic [31:0] u_hi, u_lo, p_hi, p_lo;
    int u_cnt;
    assign bus.md_hi = u_hi;
    assign bus.md_lo = u_lo;
    always @(posedge clk) begin
        if (rst) begin
            u_hi <= '0; u_lo <= '0; u_cnt <= 0;
        end else begin
            if (bus.md_enable_mult) begin
                {u_hi, u_lo} <= mul64(bus.md_mult_a, bus.md_mult_b, bus.md_signed_mult);
                mult_pulses  <= mult_pulses + 1;
            end
            if (bus.md_enable_div) begin
                u_cnt        <= DIV_LAT;
                {p_hi, p_lo} <= div64(bus.md_div_a, bus.md_div_b, bus.md_signed_div);
            end else if (u_cnt != 0) begin
                u_cnt <= u_cnt - 1;
                if (u_cnt == 1) begin
                    u_hi <= p_hi; u_lo <= p_lo;
                end
            end
        end
    end

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Presents one op (starting just after a rising edge) and holds it until accepted.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int stalls);
        bit done;
        bit dz;
        logic [3:0]   exp_ctl;
        logic [31:0]  exp_rd;
        logic [127:0] exp_opnd;
        if (op == 3'd4) exp_q.push_back(arch_hi);
        if (op == 3'd5) exp_q.push_back(arch_lo);
        bus.req_valid = 1'b1; bus.req_op = op; bus.req_a = a; bus.req_b = b;
        stalls = 0; done = 0;
`ifdef MULDIV_DIV0_TRAP_EN
        dz = (op == 3'd2 || op == 3'd3) && (b == 32'd0);
`else
        dz = 1'b0;
`endif
        while (!done) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                done    = 1;
                exp_ctl = {op <= 3'd1, op == 3'd0,
                           (op == 3'd2 || op == 3'd3) && !dz, op == 3'd2 && !dz};
                total++;
                if ({bus.md_enable_mult, bus.md_signed_mult, bus.md_enable_div, bus.md_signed_div} !== exp_ctl) begin
                    bad++;
                    $display("FAIL issue_ctl op=%0d: got %b want %b", op,
                             {bus.md_enable_mult, bus.md_signed_mult, bus.md_enable_div, bus.md_signed_div}, exp_ctl);
                end
                exp_opnd = {a, b, a, b};
                total++;
                if ({bus.md_mult_a, bus.md_mult_b, bus.md_div_a, bus.md_div_b} !== exp_opnd) begin
                    bad++;
                    $display("FAIL operands op=%0d: got %h want %h", op,
                             {bus.md_mult_a, bus.md_mult_b, bus.md_div_a, bus.md_div_b}, exp_opnd);
                end
                exp_rd = (op == 3'd4 || op == 3'd5) ? exp_q.pop_front() : 32'd0;
                total++;
                if (bus.rd_data !== exp_rd) begin
                    bad++;
                    $display("FAIL rd_data op=%0d: got %h want %h", op, bus.rd_data, exp_rd);
                end
`ifdef MULDIV_DIV0_TRAP_EN
                total++;
                if (bus.div_zero !== dz) begin
                    bad++;
                    $display("FAIL div_zero op=%0d: got %b want %b", op, bus.div_zero, dz);
                end
`endif
                case (op)
                    3'd0: {arch_hi, arch_lo} = mul64(a, b, 1'b1);
                    3'd1: {arch_hi, arch_lo} = mul64(a, b, 1'b0);
                    3'd2: if (b != 0) {arch_hi, arch_lo} = div64(a, b, 1'b1);
                    3'd3: if (b != 0) {arch_hi, arch_lo} = div64(a, b, 1'b0);
                    3'd6: arch_hi = a;
                    3'd7: arch_lo = a;
                    default: ;
                endcase
            end else begin
                stalls++;
                total++;
                if (bus.busy !== 1'b1) begin
                    bad++;
                    $display("FAIL stall_busy op=%0d: got busy=%b want 1", op, bus.busy);
                end
                if (stalls > 100) begin
                    bad++;
                    $display("FAIL accept_timeout op=%0d: got no accept want accept", op);
                    if (op == 3'd4 || op == 3'd5) void'(exp_q.pop_front());
                    done = 1;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_stall(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d stall cycles want %0d", name, got, want);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 1'b0; bus.req_op = '0; bus.req_a = '0; bus.req_b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({bus.busy, bus.rd_data, bus.md_enable_mult, bus.md_signed_mult, bus.md_enable_div, bus.md_signed_div} !== 37'd0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%b rd=%h en=%b%b%b%b want all 0", bus.busy, bus.rd_data,
                     bus.md_enable_mult, bus.md_signed_mult, bus.md_enable_div, bus.md_signed_div);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL reset_release: got ready=%b busy=%b want ready=1 busy=0", bus.req_ready, bus.busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        int s0, s1, s2, p0;
        p0 = mult_pulses;
        issue(3'd0, 32'hFFFF_FFFE, 32'd3, s0);
        issue(3'd4, 32'd0, 32'd0, s1);
        issue(3'd5, 32'd0, 32'd0, s2);
        idle(1);
        chk_stall("mult_stalls", s0 + s1 + s2, 0);
        total++;
        if (mult_pulses - p0 !== 1) begin
            bad++;
            $display("FAIL mult_pulse_count: got %0d want 1", mult_pulses - p0);
        end
    endtask

    task automatic test_divu();
        int s;
        issue(3'd3, 32'd100, 32'd7, s);
        issue(3'd5, 32'd0, 32'd0, s);
        chk_stall("divu_mflo_wait", s, DIV_LAT);
        issue(3'd4, 32'd0, 32'd0, s);
        chk_stall("divu_mfhi_wait", s, 0);
        issue(3'd2, -32'sd100, 32'd7, s);
        issue(3'd4, 32'd0, 32'd0, s);
        chk_stall("div_signed_wait", s, DIV_LAT);
        issue(3'd5, 32'd0, 32'd0, s);
        idle(1);
    endtask

    task automatic test_override();
        int s;
        issue(3'd6, 32'h1234, 32'd0, s);
        issue(3'd4, 32'd0, 32'd0, s);
        issue(3'd1, 32'd2, 32'd3, s);
        issue(3'd4, 32'd0, 32'd0, s);
        issue(3'd5, 32'd0, 32'd0, s);
        idle(1);
    endtask

    task automatic test_back_to_back();
        int s;
        issue(3'd6, 32'hA, 32'd0, s);
        issue(3'd6, 32'hB, 32'd0, s);
        issue(3'd7, 32'hC, 32'd0, s);
        issue(3'd4, 32'd0, 32'd0, s);
        issue(3'd5, 32'd0, 32'd0, s);
        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s);
        issue(3'd5, 32'd0, 32'd0, s);
        issue(3'd4, 32'd0, 32'd0, s);
        chk_stall("b2b_stalls", s, 0);
        idle(1);
    endtask

    task automatic test_reset_during_div();
        int s;
        issue(3'd2, -32'sd7, 32'd2, s);
        idle(4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        arch_hi = '0; arch_lo = '0;
        @(negedge clk);
        total++;
        if ({bus.req_ready, bus.busy} !== 2'b10) begin
            bad++;
            $display("FAIL div_reset_release: got ready=%b busy=%b want ready=1 busy=0", bus.req_ready, bus.busy);
        end
        @(posedge clk); #1;
        issue(3'd5, 32'd0, 32'd0, s);
        chk_stall("div_reset_mflo", s, 0);
        idle(1);
    endtask

    task automatic test_div_zero();
        int s;
        issue(3'd7, 32'h55, 32'd0, s);
        issue(3'd2, 32'd5, 32'd0, s);
`ifdef MULDIV_DIV0_TRAP_EN
        issue(3'd5, 32'd0, 32'd0, s);
        chk_stall("div0_trap_next", s, 0);
`else
        issue(3'd7, 32'h66, 32'd0, s);
        chk_stall("div0_full_window", s, DIV_LAT);
        issue(3'd5, 32'd0, 32'd0, s);
`endif
        idle(1);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_divu();
        test_override();
        test_back_to_back();
        test_reset_during_div();
        test_div_zero();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_controller.md
Name: muldiv_controller

Overview:
- Sequencing front-end between the integer pipeline and the shared multiplier/divider unit.
- Accepts one HI/LO-class operation per cycle: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
- Drives the unit's enable, sign and operand inputs, and tracks the multi-cycle divide.
- Stalls the pipeline on HI/LO hazards and implements MTHI/MTLO through local override registers, because the unit has no write port.

Parameters:
- DIV_LATENCY, 11: cycles the divider needs from its accepted enable until its hi/lo write lands; this is the busy-window length.
- WIDTH, 32: operand and result width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  pipeline presents an operation.
- req_op  in  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- req_a  in  WIDTH  rs operand; also the MTHI/MTLO data.
- req_b  in  WIDTH  rt operand.
- req_ready  out  1  operation accepted this cycle; the pipeline stalls while req_valid and !req_ready.
- rd_data  out  WIDTH  MFHI/MFLO result, valid combinationally in the accept cycle; 0 otherwise.
- busy  out  1  divide in flight.
- md_mult_a, md_mult_b  out  WIDTH  multiplier operands.
- md_enable_mult  out  1  multiplier issue pulse.
- md_signed_mult  out  1  signed multiply select.
- md_div_a, md_div_b  out  WIDTH  divider dividend and divisor.
- md_enable_div  out  1  divider issue pulse.
- md_signed_div  out  1  signed divide select.
- md_hi, md_lo  in  WIDTH  unit result registers.

Behaviour:
- Accept rule: accept = req_valid && req_ready. Combinationally, req_ready = !busy. Every op class waits while a divide is in flight, because a late divide write would clobber any HI/LO change.
- Multiply issue: on accepting op 0 or 1, md_enable_mult=1 in that same cycle. md_signed_mult = (op==0). md_mult_a=req_a, md_mult_b=req_b.
- Multiply latency: the result is in md_hi/md_lo the next cycle. No busy window.
- Divide issue: on accepting op 2 or 3, md_enable_div=1 in that same cycle. md_signed_div = (op==2). md_div_a=req_a, md_div_b=req_b.
- Divide busy counter: loaded with DIV_LATENCY at the accept edge. It decrements each cycle while nonzero, and busy = (counter != 0).
- Divide timing: with accept in cycle T, busy holds for cycles T+1 .. T+DIV_LATENCY. The first MFHI/MFLO can be accepted in cycle T+DIV_LATENCY+1.
- Idle outputs: when not issuing, enables are 0 and the sign selects are 0. Operand outputs pass req_a/req_b through regardless of enables.
- Override registers: hi_ovr and lo_ovr, each with a valid flag.
  - MTHI: hi_ovr<=req_a and hi_ovr_v<=1. MTLO does the same for lo.
  - Any accepted MULT/MULTU/DIV/DIVU clears both valid flags at the accept edge.
- Reads: MFHI returns hi_ovr_v ? hi_ovr : md_hi. MFLO returns the same for lo. Read results are driven in the accept cycle and have no side effects.
- State machine:
  - IDLE: accepts every op. Goes to DIV_BUSY on an accepted divide.
  - DIV_BUSY: req_ready=0. Returns to IDLE when the counter reaches 1 and decrements to 0.
- Back-to-back ops: MULT followed by MFLO on the next cycle is legal and returns the new product. Successive MTHI writes replace hi_ovr; the last one wins.
- Reset:
  - Values: counter=0, state IDLE, both valid flags and both ovr registers =0, all outputs 0 except the operand passthroughs.
  - A reset during DIV_BUSY abandons the divide. The unit is reset together with the controller, so hi/lo read 0 afterwards.
- Operand rules: no width extension; the unit owns sign handling. req_op is ignored when req_valid=0.

Optional Feature:
- Macro: MULDIV_DIV0_TRAP_EN.
- When defined:
  - Adds output div_zero (1 bit).
  - An accepted DIV/DIVU with req_b==0 does not pulse md_enable_div and does not enter DIV_BUSY.
  - Override flags are left unchanged.
  - div_zero=1 for exactly that accept cycle; div_zero resets to 0.
- When undefined:
  - No div_zero port.
  - A divide by zero issues normally and occupies the full busy window. Its HI/LO contents are architecturally unpredictable.

Test Plan:
- MULT a=0xFFFFFFFE, b=3, then MFHI and MFLO on the following cycles -> rd_data 0xFFFFFFFF then 0xFFFFFFFA. md_enable_mult pulses once with md_signed_mult=1.
- DIVU a=100, b=7 at cycle T, MFLO held valid from T+1 -> req_ready=0 for T+1..T+11. MFLO is accepted at T+12 with rd_data=14; MFHI next gives 2.
- MTHI 0x1234, then MFHI -> 0x1234. Then MULTU 2×3, then MFHI -> 0 (override cleared) and MFLO -> 6.
- DIV a=-7, b=2 with reset asserted at T+5 -> busy=0 and req_ready=1 the cycle after reset releases. MFLO returns 0.
- DIV a=5, b=0 (MULDIV_DIV0_TRAP_EN defined) -> div_zero=1 for one cycle, md_enable_div=0, and the next op is accepted immediately. With the macro undefined -> 11-cycle stall.
